alt_vipcti130_common_sample_assembler: RTL

- Receive-side counterpart of the clocked-video-output sample counter.
- Sits behind the clocked-video-input sync extractor and converts an incoming colour-plane stream into whole samples.
- In SD mode it collects NUMBER_OF_COLOUR_PLANES sequential plane cycles into one parallel sample. In HD mode it registers already-parallel samples.
- Emits one-cycle sample strobes to the downstream line/field writer.

---
 rtl/alt_vipcti130_common_sample_assembler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alt_vipcti130_common_sample_assembler.sv
// ---------------------------------------------------------------------------
// alt_vipcti130_common_sample_assembler
//
// Purpose:
//   Receive-side sample assembler for clocked video input. It sits behind the
//   sync extractor and turns the incoming colour-plane stream into whole
//   samples, emitting a one-cycle strobe per sample to the line/field writer.
//     - SD (hd_sdn=0): planes arrive one per valid cycle on vid_data[BPS-1:0]
//       and are collected into NUMBER_OF_COLOUR_PLANES slots.
//     - HD (hd_sdn=1): vid_data already carries a full parallel sample and is
//       simply registered.
//
// Ports:
//   clk           - clock
//   rst_n         - asynchronous reset, active-low
//   sclr          - synchronous clear, re-aligns the plane counter
//   hd_sdn        - 1 = parallel planes (HD), 0 = sequential planes (SD)
//   vid_datavalid - vid_data carries a plane (SD) or a sample (HD)
//   vid_data      - input data, SD uses the low BPS bits only
//   sample_data   - assembled sample, plane 0 in the low BPS bits
//   sample_valid  - one-cycle strobe, sample_data is valid
//   sample_ticks  - index of the next expected plane
//   partial_drop  - one-cycle pulse, an incomplete sample was discarded
// ---------------------------------------------------------------------------
module alt_vipcti130_common_sample_assembler #(
    parameter int BPS                          = 8,
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sclr,
    input  logic                                   hd_sdn,
    input  logic                                   vid_datavalid,
    input  logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0] vid_data,
    output logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0] sample_data,
    output logic                                   sample_valid,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
    output logic                                   partial_drop
);

    localparam int NCP = NUMBER_OF_COLOUR_PLANES;
    localparam int CW  = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam int DW  = BPS * NUMBER_OF_COLOUR_PLANES;
    localparam logic [CW-1:0] LAST_PLANE = CW'(NCP - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BPS-1:0] slots_q [NCP];
    logic [BPS-1:0] slots_d [NCP];
    logic [DW-1:0]  sampleData_q, sampleData_d;
    logic           sampleValid_q, sampleValid_d;
    logic           partialDrop_q, partialDrop_d;
    logic           lastHdSdn_q;

    logic           realign;
    logic [CW-1:0]  cntStart;
    logic [DW-1:0]  assembled;

    // Next-state logic. A clear or a mode change restarts the plane count
    // before the current cycle is processed, so the current plane (or HD
    // sample) is handled in the new alignment / new mode. Slots are written
    // by index, so values held across idle gaps never move. The assembled
    // sample merges the stored slots with the plane arriving this cycle, which
    // keeps the latency from final plane to strobe at one cycle.
    always_comb begin
        cnt_d         = cnt_q;
        slots_d       = slots_q;
        sampleData_d  = sampleData_q;
        sampleValid_d = 1'b0;
        partialDrop_d = 1'b0;
        assembled     = '0;

        realign  = sclr | (hd_sdn != lastHdSdn_q);
        cntStart = realign ? '0 : cnt_q;
        cnt_d    = cntStart;

        if (realign && (cnt_q != '0)) begin
            partialDrop_d = 1'b1;
        end

        if (vid_datavalid) begin
            if (hd_sdn) begin
                sampleData_d  = vid_data;
                sampleValid_d = 1'b1;
                cnt_d         = '0;
            end else begin
                slots_d[cntStart] = vid_data[BPS-1:0];
                for (int p = 0; p < NCP; p++) begin
                    assembled[p*BPS +: BPS] = (CW'(p) == cntStart) ? vid_data[BPS-1:0]
                                                                   : slots_q[p];
                end
                if (cntStart == LAST_PLANE) begin
                    sampleData_d  = assembled;
                    sampleValid_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cntStart + CW'(1);
                end
            end
        end
    end

    // State and output registers; reset drops any sample in progress without
    // producing a strobe or a drop pulse for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            sampleData_q  <= '0;
            sampleValid_q <= 1'b0;
            partialDrop_q <= 1'b0;
            lastHdSdn_q   <= 1'b0;
            for (int p = 0; p < NCP; p++) begin
                slots_q[p] <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            sampleData_q  <= sampleData_d;
            sampleValid_q <= sampleValid_d;
            partialDrop_q <= partialDrop_d;
            lastHdSdn_q   <= hd_sdn;
            for (int p = 0; p < NCP; p++) begin
                slots_q[p] <= slots_d[p];
            end
        end
    end

    assign sample_data  = sampleData_q;
    assign sample_valid = sampleValid_q;
    assign sample_ticks = cnt_q;
    assign partial_drop = partialDrop_q;

endmodule
